// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix coprocessor: size encoding, write-back
// FSM states and element/word count helpers.
// Optional feature macro: MATRIX_WB_CHECKSUM_EN adds the StCksum state.
package matrix_pkg;

  // Matrix order encoding: n = size + 2
  localparam logic [1:0] Size2x2 = 2'd0;
  localparam logic [1:0] Size3x3 = 2'd1;
  localparam logic [1:0] Size4x4 = 2'd2;
  localparam logic [1:0] Size5x5 = 2'd3;

  // Wide enough for 25 elements and 13 words
  localparam int unsigned ElemCntW = 5;
  localparam int unsigned WordCntW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StWrite,
    StDone
`ifdef MATRIX_WB_CHECKSUM_EN
    , StCksum
`endif
  } wb_state_e;

  // Number of matrix elements n*n for a size code
  function automatic logic [ElemCntW-1:0] elem_count(input logic [1:0] size);
    logic [ElemCntW-1:0] e;
    case (size)
      Size2x2: e = 5'd4;
      Size3x3: e = 5'd9;
      Size4x4: e = 5'd16;
      default: e = 5'd25;
    endcase
    return e;
  endfunction

  // Number of 16-bit data words, ceil(n*n/2)
  function automatic logic [WordCntW-1:0] word_count(input logic [1:0] size);
    logic [ElemCntW-1:0] e;
    e = elem_count(size);
    return WordCntW'((e + 5'd1) >> 1);
  endfunction

endpackage

// File: rtl/matrix_writeback_if.sv
// Job, element-stream and memory-write signals of the write-back stage.
// master: control unit / coprocessor side; slave: matrix_writeback.
// Unaffected by MATRIX_WB_CHECKSUM_EN.
interface matrix_writeback_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ELEM_W = 8
);
  logic                  start;
  logic [1:0]            size;
  logic [ADDR_W-1:0]     base_addr;
  logic                  res_valid;
  logic [ELEM_W-1:0]     res_data;
  logic                  res_ready;
  logic                  mem_wren;
  logic [ADDR_W-1:0]     mem_addr;
  logic [2*ELEM_W-1:0]   mem_data;
  logic                  busy;
  logic                  done;

  modport master (
    output start, size, base_addr, res_valid, res_data,
    input  res_ready, mem_wren, mem_addr, mem_data, busy, done
  );

  modport slave (
    input  start, size, base_addr, res_valid, res_data,
    output res_ready, mem_wren, mem_addr, mem_data, busy, done
  );
endinterface

// File: rtl/wb_word_packer.sv
// Low/high byte capture for the write-back stage. Holds the low byte of the
// current pair and forms the outgoing word, zero-padding an odd last element.
module wb_word_packer #(
  parameter int unsigned ELEM_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cap_low_i,
  input  logic                pad_i,
  input  logic [ELEM_W-1:0]   data_i,
  output logic [2*ELEM_W-1:0] word_o
);

  logic [ELEM_W-1:0] low_q;

  // Capture the low byte of a pair; reset discards any partial pair
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      low_q <= '0;
    end else if (cap_low_i) begin
      low_q <= data_i;
    end
  end

  // Padded word carries the element low with a zero high byte
  always_comb begin
    word_o = {data_i, low_q};
    if (pad_i) begin
      word_o = {{ELEM_W{1'b0}}, data_i};
    end
  end

endmodule

// File: rtl/matrix_writeback.sv
// Result write-back stage: packs the element stream into 16-bit words, low
// element first, writes them from base_addr upward and pulses done.
// Optional feature macro: MATRIX_WB_CHECKSUM_EN appends a checksum word.
module matrix_writeback #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ELEM_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  matrix_writeback_if.slave wb
);
  import matrix_pkg::*;

  wb_state_e             state_q;
  logic [1:0]            size_q;
  logic [ADDR_W-1:0]     base_q;
  logic [ElemCntW-1:0]   elem_idx_q;
  logic [WordCntW-1:0]   word_idx_q;
  logic                  res_ready_q;
  logic                  mem_wren_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [2*ELEM_W-1:0]   mem_data_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef MATRIX_WB_CHECKSUM_EN
  logic [2*ELEM_W-1:0]   sum_q;
`endif

  logic                  hs;
  logic                  last_elem;
  logic                  last_word;
  logic                  in_low;
  logic [2*ELEM_W-1:0]   packed_word;

  assign hs        = res_ready_q & wb.res_valid;
  assign in_low    = (state_q == StLow);
  assign last_elem = (elem_idx_q == (elem_count(size_q) - 5'd1));
  assign last_word = (word_idx_q == (word_count(size_q) - 4'd1));

  // An element taken in StLow that goes straight to StWrite is the odd last one
  wb_word_packer #(
    .ELEM_W (ELEM_W)
  ) u_packer (
    .clk_i     (clk),
    .rst_i     (rst),
    .cap_low_i (hs & in_low),
    .pad_i     (in_low),
    .data_i    (wb.res_data),
    .word_o    (packed_word)
  );

  // Job FSM with counters and registered outputs set alongside each transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      size_q      <= '0;
      base_q      <= '0;
      elem_idx_q  <= '0;
      word_idx_q  <= '0;
      res_ready_q <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MATRIX_WB_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      mem_wren_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wb.start) begin
            size_q      <= wb.size;
            base_q      <= wb.base_addr;
            elem_idx_q  <= '0;
            word_idx_q  <= '0;
`ifdef MATRIX_WB_CHECKSUM_EN
            sum_q       <= '0;
`endif
            res_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StLow;
          end
        end
        StLow, StHigh: begin
          if (hs) begin
            elem_idx_q <= elem_idx_q + 5'd1;
`ifdef MATRIX_WB_CHECKSUM_EN
            sum_q      <= sum_q + {{ELEM_W{1'b0}}, wb.res_data};
`endif
            if ((state_q == StHigh) || last_elem) begin
              res_ready_q <= 1'b0;
              mem_wren_q  <= 1'b1;
              mem_addr_q  <= base_q + ADDR_W'(word_idx_q);
              mem_data_q  <= packed_word;
              state_q     <= StWrite;
            end else begin
              state_q <= StHigh;
            end
          end
        end
        StWrite: begin
          word_idx_q <= word_idx_q + 4'd1;
          if (last_word) begin
`ifdef MATRIX_WB_CHECKSUM_EN
            mem_wren_q <= 1'b1;
            mem_addr_q <= base_q + ADDR_W'(word_count(size_q));
            mem_data_q <= sum_q;
            state_q    <= StCksum;
`else
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
`endif
          end else begin
            res_ready_q <= 1'b1;
            state_q     <= StLow;
          end
        end
`ifdef MATRIX_WB_CHECKSUM_EN
        StCksum: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StDone;
        end
`endif
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wb.res_ready = res_ready_q;
  assign wb.mem_wren  = mem_wren_q;
  assign wb.mem_addr  = mem_addr_q;
  assign wb.mem_data  = mem_data_q;
  assign wb.busy      = busy_q;
  assign wb.done      = done_q;

endmodule

// File: tb/tb_matrix_writeback.sv
// Bench for matrix_writeback: directed and randomized jobs checked against a
// word-list model built from the element array. Honours MATRIX_WB_CHECKSUM_EN.
module tb_matrix_writeback;
  localparam int ADDR_W = 8;
  localparam int ELEM_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_writeback_if #(.ADDR_W(ADDR_W), .ELEM_W(ELEM_W)) wb ();

  matrix_writeback #(.ADDR_W(ADDR_W), .ELEM_W(ELEM_W)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

`ifdef MATRIX_WB_CHECKSUM_EN
  localparam int Cks = 1;
`else
  localparam int Cks = 0;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic [7:0]  got_addr[32];
  logic [15:0] got_data[32];
  int          got_cnt = 0;
  logic [7:0]  job_el[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Every write strobe is matched in order against the expected word list
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("ready_wren_exclusive", 32'(wb.res_ready & wb.mem_wren), 32'd0);
      if (wb.mem_wren === 1'b1) begin
        if (got_cnt < 32) begin
          got_addr[got_cnt] = wb.mem_addr;
          got_data[got_cnt] = wb.mem_data;
        end
        got_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   wb.mem_addr, wb.mem_data);
        end else begin
          check("mem_addr", 32'(wb.mem_addr), 32'(exp_addr_q.pop_front()));
          check("mem_data", 32'(wb.mem_data), 32'(exp_data_q.pop_front()));
        end
      end
    end
  end

  // One job: builds the expected words, drives start and the element stream
  // (gap_min..gap_max idle cycles before each element), checks the ending.
  task automatic run_job(input logic [1:0] sz, input logic [7:0] base, input int gap_min,
                         input int gap_max, input bit check_lat, input bit restart_mid,
                         input bit abort_first);
    int n, e, w, idx, gap, gap_tgt, k, done_k, sum, lat_exp;
    bit hs, seen_done;
    logic [7:0] hi;
    n = int'(sz) + 2;
    e = n * n;
    w = (e + 1) / 2;
    sum = 0;
    for (int j = 0; j < w; j++) begin
      hi = (2 * j + 1 < e) ? job_el[2 * j + 1] : 8'h00;
      exp_addr_q.push_back(base + 8'(j));
      exp_data_q.push_back({hi, job_el[2 * j]});
    end
    for (int j = 0; j < e; j++) sum += int'(job_el[j]);
    if (Cks == 1) begin
      exp_addr_q.push_back(base + 8'(w));
      exp_data_q.push_back(16'(sum));
    end
    lat_exp = 1 + 3 * (e / 2) + 2 * (e % 2) + 1 + Cks;

    got_cnt = 0;
    idx = 0;
    gap = 0;
    gap_tgt = $urandom_range(gap_max, gap_min);
    hs = 1'b0;
    seen_done = 1'b0;
    done_k = 0;

    @(negedge clk);
    wb.start = 1'b1;
    wb.size = sz;
    wb.base_addr = base;
    wb.res_valid = 1'b0;
    for (k = 1; k <= 400 && !seen_done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        wb.start = 1'b0;
        check("busy_after_start", 32'(wb.busy), 32'd1);
      end
      if (restart_mid && k == 4) begin
        wb.start = 1'b1;
        wb.size = ~sz;
        wb.base_addr = ~base;
      end
      if (restart_mid && k == 5) wb.start = 1'b0;
      if (abort_first && wb.mem_wren === 1'b1) begin
        #1;
        exp_addr_q.delete();
        exp_data_q.delete();
        rst = 1'b1;
        wb.res_valid = 1'b0;
        @(negedge clk);
        check("abort_mem_wren", 32'(wb.mem_wren), 32'd0);
        check("abort_busy", 32'(wb.busy), 32'd0);
        check("abort_res_ready", 32'(wb.res_ready), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_write_count", 32'(got_cnt), 32'd1);
        return;
      end
      if (wb.done === 1'b1) begin
        seen_done = 1'b1;
        done_k = k;
      end else begin
        if (hs) begin
          idx++;
          gap = 0;
          gap_tgt = $urandom_range(gap_max, gap_min);
        end
        if (idx >= e) begin
          wb.res_valid = 1'b0;
        end else if (!(wb.res_valid === 1'b1 && !hs)) begin
          if (gap < gap_tgt) begin
            wb.res_valid = 1'b0;
            wb.res_data = 8'($urandom);
            gap++;
          end else begin
            wb.res_valid = 1'b1;
            wb.res_data = job_el[idx];
          end
        end
        hs = (wb.res_valid === 1'b1) && (wb.res_ready === 1'b1);
      end
    end
    wb.res_valid = 1'b0;
    check("done_seen", 32'(seen_done), 32'd1);
    check("elems_consumed", 32'(idx), 32'(e));
    if (check_lat) check("latency", 32'(done_k + 1), 32'(lat_exp));
    check("busy_low_at_done", 32'(wb.busy), 32'd0);
    @(negedge clk);
    check("done_single_cycle", 32'(wb.done), 32'd0);
    check("writes_outstanding", 32'(exp_addr_q.size()), 32'd0);
    check("write_count", 32'(got_cnt), 32'(w + Cks));
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wb.start = 1'b0;
    wb.size = 2'd0;
    wb.base_addr = 8'h00;
    wb.res_valid = 1'b0;
    wb.res_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_res_ready", 32'(wb.res_ready), 32'd0);
    check("rst_mem_wren", 32'(wb.mem_wren), 32'd0);
    check("rst_mem_addr", 32'(wb.mem_addr), 32'd0);
    check("rst_mem_data", 32'(wb.mem_data), 32'd0);
    check("rst_busy", 32'(wb.busy), 32'd0);
    check("rst_done", 32'(wb.done), 32'd0);
    rst = 1'b0;

    // 2x2 at 0x10, elements 1..4, valid held high
    for (int i = 0; i < 25; i++) job_el[i] = 8'(i + 1);
    run_job(2'd0, 8'h10, 0, 0, 1'b1, 1'b0, 1'b0);
    check("t2x2_w0_data", 32'(got_data[0]), 32'h0201);
    check("t2x2_w0_addr", 32'(got_addr[0]), 32'h10);
    check("t2x2_w1_data", 32'(got_data[1]), 32'h0403);
    check("t2x2_w1_addr", 32'(got_addr[1]), 32'h11);

    // 3x3 at 0x20, elements 1..9: padded last word
    run_job(2'd1, 8'h20, 0, 0, 1'b1, 1'b0, 1'b0);
    check("t3x3_w4_data", 32'(got_data[4]), 32'h0009);
    check("t3x3_w4_addr", 32'(got_addr[4]), 32'h24);

    // 5x5 at 0xF8, all 0xFF: address wrap
    for (int i = 0; i < 25; i++) job_el[i] = 8'hFF;
    run_job(2'd3, 8'hF8, 0, 0, 1'b1, 1'b0, 1'b0);
    check("t5x5_w7_addr", 32'(got_addr[7]), 32'hFF);
    check("t5x5_w8_addr", 32'(got_addr[8]), 32'h00);
    check("t5x5_w12_addr", 32'(got_addr[12]), 32'h04);
    check("t5x5_w12_data", 32'(got_data[12]), 32'h00FF);
    check("t5x5_w0_data", 32'(got_data[0]), 32'hFFFF);

    // 2x2 with three idle cycles before each element and a stray start
    for (int i = 0; i < 25; i++) job_el[i] = 8'(i + 1);
    run_job(2'd0, 8'h40, 3, 3, 1'b0, 1'b1, 1'b0);
    check("tstall_w1_data", 32'(got_data[1]), 32'h0403);
    check("tstall_w1_addr", 32'(got_addr[1]), 32'h41);

    // 4x4 aborted by reset after its first write, then a clean 2x2
    for (int i = 0; i < 25; i++) job_el[i] = 8'($urandom);
    run_job(2'd2, 8'h60, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 25; i++) job_el[i] = 8'(i + 1);
    run_job(2'd0, 8'h70, 0, 0, 1'b1, 1'b0, 1'b0);
    check("tpost_w0_data", 32'(got_data[0]), 32'h0201);
    check("tpost_w0_addr", 32'(got_addr[0]), 32'h70);

`ifdef MATRIX_WB_CHECKSUM_EN
    job_el[0] = 8'h80;
    job_el[1] = 8'h80;
    job_el[2] = 8'h80;
    job_el[3] = 8'h81;
    run_job(2'd0, 8'h30, 0, 0, 1'b1, 1'b0, 1'b0);
    check("tcks_w0_data", 32'(got_data[0]), 32'h8080);
    check("tcks_w1_data", 32'(got_data[1]), 32'h8180);
    check("tcks_data", 32'(got_data[2]), 32'h0201);
    check("tcks_addr", 32'(got_addr[2]), 32'h32);
`endif

    // Randomized jobs: random size, base, data and stall pattern
    repeat (16) begin
      logic [1:0] sz;
      int gmax;
      sz = 2'($urandom_range(3, 0));
      gmax = $urandom_range(2, 0);
      for (int i = 0; i < 25; i++) job_el[i] = 8'($urandom);
      run_job(sz, 8'($urandom), 0, gmax, (gmax == 0), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_writeback.md
# matrix_writeback

Result write-back stage directly downstream of the matrix coprocessor's control unit. It accepts the result matrix as a stream of 8-bit elements and packs element pairs into 16-bit words, low byte first, matching the operand layout used on the fetch side. It writes the words to the shared 8-bit-address, 16-bit-data memory starting at a base address, then pulses `done`.

## Interface
- `ADDR_W`, 8, memory address width
- `ELEM_W`, 8, matrix element width; memory word is `2*ELEM_W`
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a write-back job; sampled only in IDLE
- `size` in 2: matrix order n = `size`+2 (00→2x2 … 11→5x5); latched on accepted `start`
- `base_addr` in `ADDR_W`: first word address; latched on accepted `start`
- `res_valid` in 1: coprocessor presents an element on `res_data`
- `res_data` in `ELEM_W`: element, row-major order
- `res_ready` out 1: element accepted on cycles where `res_valid && res_ready`
- `mem_wren` out 1: memory write strobe, one cycle per word
- `mem_addr` out `ADDR_W`: write address
- `mem_data` out `2*ELEM_W`: write data
- `busy` out 1: high from the cycle after accepted `start` until `done`
- `done` out 1: one-cycle pulse at job end

## Operation
- Element count E = n² (4/9/16/25). Data word count W = ceil(E/2) (2/5/8/13).
- States:
  - IDLE: on `start`, latch `size`/`base_addr`, clear counters, go to LOW.
  - LOW: `res_ready`=1; on handshake capture the low byte. If this is the last element, clear the high byte to 0 and go to WRITE; otherwise go to HIGH.
  - HIGH: `res_ready`=1; on handshake capture the high byte and go to WRITE.
  - WRITE: `mem_wren`=1, `mem_addr`=`base_addr`+word_idx (mod 2^ADDR_W, wraps 255→0). Increment word_idx. If last word, go to CKSUM (macro on) or DONE; otherwise go to LOW.
  - CKSUM: see Configuration.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `res_ready` is 0 in IDLE, WRITE, CKSUM and DONE; the producer must hold `res_valid`/`res_data` while stalled.
- `start` outside IDLE is ignored. No job queuing.
- `res_valid` in IDLE is ignored; no data is consumed.
- Reset mid-job aborts it: next cycle is IDLE with no write issued and partial bytes discarded.
- Reset values: `res_ready`=0, `mem_wren`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `done`=0.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from input to output.
- Per full word with `res_valid` held high: 3 cycles (LOW, HIGH, WRITE). For a padded last word: 2 cycles.
- Job latency from `start` cycle to `done` pulse with no stalls: 1 + 3·floor(E/2) + 2·(E mod 2) + 1 cycles (+1 with checksum). Example: 2x2 = 8 cycles.
- `mem_addr`/`mem_data` are valid only while `mem_wren`=1 and hold their last value otherwise.

## Configuration
- `MATRIX_WB_CHECKSUM_EN`:
  - Defined: CKSUM state writes one extra word at `base_addr`+W (wrapping), with data equal to the 16-bit modular sum of all E elements, each zero-extended. `mem_wren`=1 for that cycle. `done` comes one cycle later.
  - Undefined: no CKSUM state, no accumulator, exactly W writes.

## Structure
- Shared package `matrix_pkg`:
  - size encoding constants
  - state enum
  - `elem_count(size)` and `word_count(size)` functions, also usable by the control unit and fetch stage
- Optional sub-module `wb_word_packer`: low/high byte capture and pad logic. The FSM, counters and address adder stay in the top module.

## Test plan
- 2x2, `base_addr`=0x10, elements 1,2,3,4 with `res_valid` held high → writes 0x0201@0x10 and 0x0403@0x11; `done` 8 cycles after `start`.
- 3x3, `base_addr`=0x20, elements 1..9 → 5 writes; last word 0x0009@0x24.
- 5x5, `base_addr`=0xF8, elements 0xFF → 13 writes; addresses 0xF8..0xFF then 0x00..0x04; last word 0x00FF.
- 2x2 with `res_valid` low for 3 cycles before each element → stall, data unchanged, correct words; second `start` mid-job ignored.
- `rst` asserted after the first write of a 4x4 job → `mem_wren`=0 next cycle, `busy`=0, no further writes; a fresh 2x2 job then completes normally.
- With `MATRIX_WB_CHECKSUM_EN`, 2x2 elements 0x80,0x80,0x80,0x81 → extra write 0x0201@`base_addr`+2; `done` at cycle 9.
